// File: rtl/alu_result_bcd.sv
// rtl/alu_result_bcd.sv - ALU result to sign + packed BCD converter (iterative double dabble)
`timescale 1ns/1ps

module alu_result_bcd #(
  parameter int WIDTH     = 20,
  parameter int DIGITS    = 7,
  parameter int SIGNED_IN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      din,
  output logic                  busy,
  output logic                  done,
  output logic                  neg,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [WIDTH-1:0]    r_mag;
  logic [4*DIGITS-1:0] r_scratch;
  logic [CW-1:0]       r_count;
  logic                r_sign;
  logic                r_done;
  logic                r_neg;
  logic [4*DIGITS-1:0] r_bcd;
  logic [WIDTH-1:0]    w_mag_in;
  logic                w_sign_in;
  logic [4*DIGITS-1:0] w_adj;

  // Sign/magnitude split of the input; the most negative value negates to itself,
  // which read as unsigned is exactly the required magnitude.
  always_comb begin
    w_sign_in = 1'b0;
    w_mag_in  = din;
    if ((SIGNED_IN != 0) && din[WIDTH-1]) begin
      w_sign_in = 1'b1;
      w_mag_in  = ~din + WIDTH'(1);
    end
  end

  // Add-3 correction on every scratch digit that would overflow past 9 after doubling
  always_comb begin
    w_adj = r_scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_scratch[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  // Next-state logic: one shift per cycle, WIDTH shifts, then a single DONE cycle
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_SHIFT;
      S_SHIFT: if (r_count == CW'(WIDTH - 1)) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Working registers and held outputs; done is a registered one-cycle pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mag     <= '0;
      r_scratch <= '0;
      r_count   <= '0;
      r_sign    <= 1'b0;
      r_done    <= 1'b0;
      r_neg     <= 1'b0;
      r_bcd     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mag     <= w_mag_in;
            r_sign    <= w_sign_in;
            r_scratch <= '0;
            r_count   <= '0;
          end
        end
        S_SHIFT: begin
          {r_scratch, r_mag} <= {w_adj[4*DIGITS-2:0], r_mag, 1'b0};
          r_count            <= r_count + CW'(1);
        end
        S_DONE: begin
          r_bcd  <= r_scratch;
          r_neg  <= r_sign;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign neg  = r_neg;
  assign bcd  = r_bcd;

endmodule

// File: tb/tb_alu_result_bcd.sv
// tb/tb_alu_result_bcd.sv - self-checking bench for alu_result_bcd (signed and unsigned instances)
`timescale 1ns/1ps

module tb_alu_result_bcd;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_start, u_start;
  logic [19:0] s_din, u_din;
  logic        s_busy, s_done, s_neg;
  logic        u_busy, u_done, u_neg;
  logic [27:0] s_bcd, u_bcd;

  int n_checks = 0;
  int n_fail   = 0;
  logic [27:0] last_s_bcd = '0;

  always #5 clk = ~clk;

  alu_result_bcd #(.WIDTH(20), .DIGITS(7), .SIGNED_IN(1)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .din(s_din),
    .busy(s_busy), .done(s_done), .neg(s_neg), .bcd(s_bcd)
  );

  alu_result_bcd #(.WIDTH(20), .DIGITS(7), .SIGNED_IN(0)) dut_u (
    .clk(clk), .rst(rst), .start(u_start), .din(u_din),
    .busy(u_busy), .done(u_done), .neg(u_neg), .bcd(u_bcd)
  );

  typedef struct {
    logic [19:0] din;
    logic [27:0] bcd;
    logic        neg;
    bit          uns;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decimal reference: divide-by-ten digit extraction, independent of shift-add-3
  function automatic logic [28:0] ref_conv(input logic [19:0] d, input bit sgn);
    logic [20:0] m;
    logic [27:0] b;
    logic        n;
    n = sgn && d[19];
    m = n ? (21'h100000 - {1'b0, d}) : {1'b0, d};
    b = '0;
    for (int i = 0; i < 7; i++) begin
      b[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return {n, b};
  endfunction

  // One conversion: pulse start, check busy, latency, result and done width
  task automatic conv(input logic [19:0] d, input logic [27:0] eb, input logic en,
                      input bit uns, input string name);
    int  lat;
    bit  found;
    logic dn;
    lat = 0;
    found = 0;
    @(negedge clk);
    if (uns) begin u_din = d; u_start = 1'b1; end
    else     begin s_din = d; s_start = 1'b1; end
    @(posedge clk);
    #1;
    u_start = 1'b0;
    s_start = 1'b0;
    chk($sformatf("%s busy", name), uns ? u_busy : s_busy, 1);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      dn = uns ? u_done : s_done;
      if (dn) begin
        lat = k;
        found = 1;
        break;
      end
    end
    chk($sformatf("%s done seen", name), found, 1);
    chk($sformatf("%s latency", name), lat, 21);
    chk($sformatf("%s bcd", name), uns ? u_bcd : s_bcd, eb);
    chk($sformatf("%s neg", name), uns ? u_neg : s_neg, en);
    if (!uns) last_s_bcd = eb;
    @(posedge clk);
    #1;
    chk($sformatf("%s done one cycle", name), uns ? u_done : s_done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[12];
    logic [28:0] r;
    logic [19:0] d;
    int          t_exp[3];
    logic [27:0] b_exp[3];
    logic        n_exp[3];
    int          idx;
    int          ndone;

    tbl[0]  = '{20'd18,    28'h0000018, 1'b0, 1'b0};
    tbl[1]  = '{20'hFFFFD, 28'h0000003, 1'b1, 1'b0};
    tbl[2]  = '{20'h80000, 28'h0524288, 1'b1, 1'b0};
    tbl[3]  = '{20'h7FFFF, 28'h0524287, 1'b0, 1'b0};
    tbl[4]  = '{20'd0,     28'h0000000, 1'b0, 1'b0};
    tbl[5]  = '{20'hFFFFF, 28'h0000001, 1'b1, 1'b0};
    tbl[6]  = '{20'd99999, 28'h0099999, 1'b0, 1'b0};
    tbl[7]  = '{20'hFFC19, 28'h0000999, 1'b1, 1'b0};
    tbl[8]  = '{20'd1,     28'h0000001, 1'b0, 1'b0};
    tbl[9]  = '{20'hFFFFF, 28'h1048575, 1'b0, 1'b1};
    tbl[10] = '{20'd120,   28'h0000120, 1'b0, 1'b1};
    tbl[11] = '{20'h80000, 28'h0524288, 1'b0, 1'b1};

    rst = 1'b1;
    s_start = 1'b0; u_start = 1'b0;
    s_din = '0; u_din = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset s_busy", s_busy, 0);
    chk("reset s_done", s_done, 0);
    chk("reset s_neg",  s_neg,  0);
    chk("reset s_bcd",  s_bcd,  0);
    chk("reset u_busy", u_busy, 0);
    chk("reset u_bcd",  u_bcd,  0);

    for (int i = 0; i < 12; i++) begin
      conv(tbl[i].din, tbl[i].bcd, tbl[i].neg, tbl[i].uns, $sformatf("vec%0d", i));
    end

    // ALU pattern sweep: op1 = 0..14, op2 = 3 over add/sub/shl/shr
    for (int op1 = 0; op1 < 15; op1++) begin
      for (int op = 0; op < 4; op++) begin
        case (op)
          0:       d = 20'(op1 + 3);
          1:       d = 20'(op1 - 3);
          2:       d = 20'(op1 << 3);
          default: d = 20'(op1 >> 3);
        endcase
        r = ref_conv(d, 1'b1);
        conv(d, r[27:0], r[28], 1'b0, $sformatf("sweep op1=%0d op=%0d", op1, op));
      end
    end

    // start held high, din changed mid-conversion: results follow din at acceptance
    t_exp = '{21, 43, 65};
    b_exp = '{28'h0004321, 28'h0000200, 28'h0000077};
    n_exp = '{1'b0, 1'b1, 1'b0};
    idx = 0;
    ndone = 0;
    @(negedge clk);
    s_din = 20'd4321;
    s_start = 1'b1;
    @(posedge clk);
    #1;
    for (int t = 1; t <= 70; t++) begin
      @(posedge clk);
      #1;
      if (t == 5)  s_din = 20'hFFF38;
      if (t == 27) s_din = 20'd77;
      if (t == 10) chk("hold prev bcd", s_bcd, last_s_bcd);
      if (t == 30) chk("hold A bcd", s_bcd, 28'h0004321);
      if (s_done) begin
        ndone++;
        if (idx < 3) begin
          chk($sformatf("hold done%0d time", idx), t, t_exp[idx]);
          chk($sformatf("hold done%0d bcd", idx), s_bcd, b_exp[idx]);
          chk($sformatf("hold done%0d neg", idx), s_neg, n_exp[idx]);
          idx++;
        end
      end
      if (t == 65) s_start = 1'b0;
    end
    chk("hold done count", ndone, 3);
    repeat (25) @(posedge clk);
    #1;
    chk("hold idle after", s_busy, 0);
    last_s_bcd = 28'h0000077;

    // Reset during SHIFT at count = 10: abort, no done, outputs cleared
    @(negedge clk);
    s_din = 20'd5555;
    s_start = 1'b1;
    @(posedge clk);
    #1;
    s_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst busy", s_busy, 0);
    chk("midrst done", s_done, 0);
    chk("midrst bcd",  s_bcd,  0);
    chk("midrst neg",  s_neg,  0);
    ndone = 0;
    for (int t = 0; t < 30; t++) begin
      @(posedge clk);
      #1;
      if (s_done) ndone++;
    end
    chk("midrst no done", ndone, 0);
    conv(20'hFFFF0, 28'h0000016, 1'b1, 1'b0, "after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
